// File: rtl/cpu86_exec_register_writer.sv
// cpu86_exec_register_writer
// Owns the cpu86 architectural register file for the execute stage. It applies
// GPR writebacks (ports A and B), flags writebacks and retire events. For each
// retired instruction it emits one snapshot on the vld_* stream, which feeds the
// exec register-reader/checker.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   wra_*, wrb_*           GPR write ports (valid/dest/w/data); port B wins on a shared byte lane
//   flw_*                  flags write (valid/mask/data)
//   ret_*                  retire event (valid/op/code/cs/ip)
//   ax..di, fl, cs, ip     current architectural register values (registered)
//   vld_*                  per-retire snapshot; data holds while vld_valid is low
//
// Optional build macro: CPU86_VLD_SEQ_EN adds the vld_seq output, a 16-bit
// retire sequence number that starts at 0 after reset.
module cpu86_exec_register_writer #(
    parameter logic [15:0] CS_RESET = 16'hFFFF,
    parameter logic [15:0] IP_RESET = 16'h0000,
    parameter logic [15:0] FL_RESET = 16'hF002
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wra_valid,
    input  logic [2:0]  wra_dest,
    input  logic        wra_w,
    input  logic [15:0] wra_data,
    input  logic        wrb_valid,
    input  logic [2:0]  wrb_dest,
    input  logic        wrb_w,
    input  logic [15:0] wrb_data,
    input  logic        flw_valid,
    input  logic [15:0] flw_mask,
    input  logic [15:0] flw_data,
    input  logic        ret_valid,
    input  logic [4:0]  ret_op,
    input  logic [3:0]  ret_code,
    input  logic [15:0] ret_cs,
    input  logic [15:0] ret_ip,
    output logic [15:0] ax,
    output logic [15:0] bx,
    output logic [15:0] cx,
    output logic [15:0] dx,
    output logic [15:0] bp,
    output logic [15:0] sp,
    output logic [15:0] si,
    output logic [15:0] di,
    output logic [15:0] fl,
    output logic [15:0] cs,
    output logic [15:0] ip,
    output logic        vld_valid,
    output logic [4:0]  vld_op,
    output logic [3:0]  vld_code,
    output logic [15:0] vld_cs,
    output logic [15:0] vld_ip,
    output logic [15:0] vld_ax,
    output logic [15:0] vld_bx,
    output logic [15:0] vld_cx,
    output logic [15:0] vld_dx,
    output logic [15:0] vld_bp,
    output logic [15:0] vld_sp,
    output logic [15:0] vld_si,
    output logic [15:0] vld_di,
    output logic [15:0] vld_fl
`ifdef CPU86_VLD_SEQ_EN
    ,
    output logic [15:0] vld_seq
`endif
);

    localparam int unsigned NUM_GPR = 8;
    localparam int unsigned W       = 16;

    // Flag bits that are architecturally fixed regardless of writes
    localparam logic [W-1:0] FL_FORCE_SET = 16'hF002;
    localparam logic [W-1:0] FL_FORCE_CLR = 16'h0028;

    // GPRs indexed by x86 register code: AX CX DX BX SP BP SI DI
    logic [NUM_GPR-1:0][W-1:0] gpr_q, gpr_n;
    logic [W-1:0]              fl_q, fl_n;
    logic [W-1:0]              cs_q, ip_q;

    // Apply one write port; byte codes 0-3 hit the low lane, 4-7 the high lane of AX/CX/DX/BX
    function automatic logic [NUM_GPR-1:0][W-1:0] apply_wr(
        input logic [NUM_GPR-1:0][W-1:0] r,
        input logic                      v,
        input logic [2:0]                d,
        input logic                      w,
        input logic [W-1:0]              data
    );
        logic [NUM_GPR-1:0][W-1:0] o;
        o = r;
        if (v) begin
            if (w)
                o[d] = data;
            else if (!d[2])
                o[{1'b0, d[1:0]}][7:0] = data[7:0];
            else
                o[{1'b0, d[1:0]}][15:8] = data[7:0];
        end
        return o;
    endfunction

    // Next-state: port B applied after A so it wins any shared lane
    always_comb begin
        gpr_n = apply_wr(apply_wr(gpr_q, wra_valid, wra_dest, wra_w, wra_data),
                         wrb_valid, wrb_dest, wrb_w, wrb_data);
        fl_n = fl_q;
        if (flw_valid)
            fl_n = (((fl_q & ~flw_mask) | (flw_data & flw_mask)) | FL_FORCE_SET) & ~FL_FORCE_CLR;
    end

    // Architectural state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gpr_q <= '0;
            fl_q  <= FL_RESET;
            cs_q  <= CS_RESET;
            ip_q  <= IP_RESET;
        end else begin
            gpr_q <= gpr_n;
            fl_q  <= fl_n;
            if (ret_valid) begin
                cs_q <= ret_cs;
                ip_q <= ret_ip;
            end
        end
    end

    // Snapshot stream: captures next-state so same-cycle writes are included
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_valid <= 1'b0;
            vld_op    <= '0;
            vld_code  <= '0;
            vld_cs    <= '0;
            vld_ip    <= '0;
            vld_ax    <= '0;
            vld_cx    <= '0;
            vld_dx    <= '0;
            vld_bx    <= '0;
            vld_sp    <= '0;
            vld_bp    <= '0;
            vld_si    <= '0;
            vld_di    <= '0;
            vld_fl    <= '0;
        end else begin
            vld_valid <= ret_valid;
            if (ret_valid) begin
                vld_op   <= ret_op;
                vld_code <= ret_code;
                vld_cs   <= ret_cs;
                vld_ip   <= ret_ip;
                vld_ax   <= gpr_n[0];
                vld_cx   <= gpr_n[1];
                vld_dx   <= gpr_n[2];
                vld_bx   <= gpr_n[3];
                vld_sp   <= gpr_n[4];
                vld_bp   <= gpr_n[5];
                vld_si   <= gpr_n[6];
                vld_di   <= gpr_n[7];
                vld_fl   <= fl_n;
            end
        end
    end

`ifdef CPU86_VLD_SEQ_EN
    logic [W-1:0] seq_q;

    // Retire sequence number; snapshot carries the pre-increment value
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seq_q   <= '0;
            vld_seq <= '0;
        end else if (ret_valid) begin
            vld_seq <= seq_q;
            seq_q   <= seq_q + W'(1);
        end
    end
`endif

    assign ax = gpr_q[0];
    assign cx = gpr_q[1];
    assign dx = gpr_q[2];
    assign bx = gpr_q[3];
    assign sp = gpr_q[4];
    assign bp = gpr_q[5];
    assign si = gpr_q[6];
    assign di = gpr_q[7];
    assign fl = fl_q;
    assign cs = cs_q;
    assign ip = ip_q;

endmodule
